// File: rtl/aes_inv_round_sequencer.sv
// aes_inv_round_sequencer: iterative AES-128 inverse-cipher controller feeding an external
// combinational inverse-round unit. Define AES_SEQ_BACK_TO_BACK_EN to accept the next block from DONE.
module aes_inv_round_sequencer #(
    parameter int NR  = 10,
    parameter int BLK = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:BLK-1]        in_block,
    input  logic [0:(NR+1)*BLK-1] words,
    output logic [0:BLK-1]        rnd_state_o,
    output logic [0:BLK-1]        rnd_key_o,
    output logic                  rnd_last_o,
    input  logic [0:BLK-1]        rnd_out_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:BLK-1]        out_block,
    output logic                  busy,
    output logic [3:0]            round_idx
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [3:0] FIRST_CNT = 4'(NR - 1);

    logic [1:0]     fsm;
    logic [0:BLK-1] state_q;
    logic [3:0]     cnt;
    logic           accept;
    logic [0:BLK-1] keys [0:NR];

    for (genvar g = 0; g <= NR; g++) begin : g_keys
        assign keys[g] = words[g*BLK +: BLK];
    end

    // in_ready is gated by rst_n so nothing is offered while reset is held
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            if (fsm == IDLE) begin
                in_ready = 1'b1;
            end
`ifdef AES_SEQ_BACK_TO_BACK_EN
            else if (fsm == DONE) begin
                in_ready = out_ready;
            end
`endif
        end
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm     <= IDLE;
            state_q <= '0;
            cnt     <= 4'd0;
        end else if (accept) begin
            // initial AddRoundKey with the last round key happens on the accept edge
            state_q <= in_block ^ keys[NR];
            cnt     <= FIRST_CNT;
            fsm     <= ROUND;
        end else begin
            case (fsm)
                ROUND: begin
                    state_q <= rnd_out_i;
                    if (cnt == 4'd0) begin
                        fsm <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm <= IDLE;
                    end
                end
                IDLE: begin
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rnd_state_o = '0;
        rnd_key_o   = '0;
        rnd_last_o  = 1'b0;
        if (fsm == ROUND) begin
            rnd_state_o = state_q;
            rnd_key_o   = keys[cnt];
            rnd_last_o  = (cnt == 4'd0);
        end
    end

    assign out_valid = (fsm == DONE);
    assign out_block = out_valid ? state_q : '0;
    assign busy      = (fsm == ROUND) || (fsm == DONE);
    assign round_idx = cnt;

endmodule

// File: tb/tb_aes_inv_round_sequencer.sv
// tb_aes_inv_round_sequencer: directed bench with a software AES inverse-round unit and
// reference cipher; honours AES_SEQ_BACK_TO_BACK_EN for the DONE-state handshake.
module tb_aes_inv_round_sequencer;

`ifdef AES_SEQ_BACK_TO_BACK_EN
    localparam int PERIOD = 11;
    localparam bit BTB    = 1'b1;
`else
    localparam int PERIOD = 12;
    localparam bit BTB    = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [0:127]   in_block;
    logic [0:1407]  words;
    logic [0:127]   rnd_state_o;
    logic [0:127]   rnd_key_o;
    logic           rnd_last_o;
    logic [0:127]   rnd_out_i;
    logic           out_valid;
    logic           out_ready;
    logic [0:127]   out_block;
    logic           busy;
    logic [3:0]     round_idx;

    int tests_run = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    aes_inv_round_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .words      (words),
        .rnd_state_o(rnd_state_o),
        .rnd_key_o  (rnd_key_o),
        .rnd_last_o (rnd_last_o),
        .rnd_out_i  (rnd_out_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_block  (out_block),
        .busy       (busy),
        .round_idx  (round_idx)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r, b;
        r = 8'h01; b = x;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) r = gmul(r, b);
            b = gmul(b, b);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0] m [4];
        logic [7:0] b;
        o = '0;
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++)
                    b = b ^ gmul(m[(j - r + 4) % 4], s[127-8*(j+4*c) -: 8]);
                o[127-8*(r+4*c) -: 8] = b;
            end
        end
        return o;
    endfunction

    function automatic logic [1407:0] key_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        logic [1407:0] kw;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rcon, 24'h000000};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        kw = '0;
        for (int i = 0; i < 44; i++) kw[1407-32*i -: 32] = w[i];
        return kw;
    endfunction

    function automatic logic [127:0] rk(input logic [1407:0] kw, input int r);
        return kw[1407-128*r -: 128];
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
        return last ? t : mix_columns(t, 1'b1);
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] p, input logic [1407:0] kw);
        logic [127:0] s;
        s = p ^ rk(kw, 0);
        for (int r = 1; r < 10; r++)
            s = mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk(kw, r);
        return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk(kw, 10);
    endfunction

    function automatic logic [127:0] aes_decrypt(input logic [127:0] c, input logic [1407:0] kw);
        logic [127:0] s;
        s = c ^ rk(kw, 10);
        for (int r = 9; r >= 0; r--) s = inv_round(s, rk(kw, r), r == 0);
        return s;
    endfunction

    // behavioural stand-in for the external inverse-round datapath
    always_comb rnd_out_i = inv_round(rnd_state_o, rnd_key_o, rnd_last_o);

    task automatic check_vec(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        tests_run++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // called at a negedge with the sequencer idle; returns at a negedge with it idle again
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] exp);
        int lat;
        in_block = ct;
        in_valid = 1'b1;
        check_bit({tag, " in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_block = '0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check_vec({tag, " latency"}, 128'(lat), 128'd10);
        check_vec({tag, " out_block"}, out_block, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_bit({tag, " out_valid drop"}, out_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1407:0] kc1, kb, kz;
        logic [127:0]  s_model;
        logic [127:0]  pts [4];
        logic [127:0]  cts [4];
        int            acc [4];
        int            in_idx, out_idx, cyc;
        bit            saw;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_block  = '0;
        out_ready = 1'b0;
        kc1 = key_expand(128'h000102030405060708090a0b0c0d0e0f);
        kb  = key_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        kz  = key_expand(128'h0);
        words = kc1;

        // reset state
        repeat (2) @(negedge clk);
        check_bit("rst in_ready", in_ready, 1'b0);
        check_bit("rst out_valid", out_valid, 1'b0);
        check_bit("rst busy", busy, 1'b0);
        check_bit("rst rnd_last_o", rnd_last_o, 1'b0);
        check_vec("rst round_idx", 128'(round_idx), 128'd0);
        check_vec("rst out_block", out_block, 128'h0);
        check_vec("rst rnd_state_o", rnd_state_o, 128'h0);
        check_vec("rst rnd_key_o", rnd_key_o, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("idle in_ready", in_ready, 1'b1);
        check_bit("idle no X", $isunknown({in_ready, out_valid, out_block, busy, round_idx,
                                           rnd_state_o, rnd_key_o, rnd_last_o}), 1'b0);

        // C.1 vector with a full round trace; stray in_valid pulses during ROUND
        in_block = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        in_valid = 1'b1;
        s_model  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a ^ rk(kc1, 10);
        @(negedge clk);
        in_block = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        in_valid = 1'b0;
        for (int r = 9; r >= 0; r--) begin
            check_vec($sformatf("trace r%0d round_idx", r), 128'(round_idx), 128'(r));
            check_vec($sformatf("trace r%0d key", r), rnd_key_o, rk(kc1, r));
            check_vec($sformatf("trace r%0d state", r), rnd_state_o, s_model);
            check_bit($sformatf("trace r%0d last", r), rnd_last_o, r == 0);
            check_bit($sformatf("trace r%0d in_ready", r), in_ready, 1'b0);
            check_bit($sformatf("trace r%0d out_valid", r), out_valid, 1'b0);
            check_bit($sformatf("trace r%0d busy", r), busy, 1'b1);
            s_model  = inv_round(s_model, rk(kc1, r), r == 0);
            in_valid = (r % 2 == 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_bit("c1 out_valid", out_valid, 1'b1);
        check_vec("c1 out_block", out_block, 128'h00112233445566778899aabbccddeeff);
        check_bit("c1 done busy", busy, 1'b1);
        check_bit("c1 done last", rnd_last_o, 1'b0);
        check_vec("c1 done key", rnd_key_o, 128'h0);
        out_ready = 1'b1;
        check_bit("c1 done in_ready", in_ready, BTB);
        @(negedge clk);
        out_ready = 1'b0;
        check_bit("c1 exit out_valid", out_valid, 1'b0);
        check_bit("c1 exit busy", busy, 1'b0);
        check_bit("c1 exit in_ready", in_ready, 1'b1);

        // backpressure with the FIPS-197 appendix B vector
        words    = kb;
        in_block = 128'h3925841d02dc09fbdc118597196a0b32;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_block = 128'hcafef00dcafef00dcafef00dcafef00d;
            check_bit($sformatf("bp%0d out_valid", i), out_valid, 1'b1);
            check_vec($sformatf("bp%0d out_block", i), out_block,
                      128'h3243f6a8885a308d313198a2e0370734);
            check_bit($sformatf("bp%0d in_ready", i), in_ready, 1'b0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_bit("bp release busy", busy, 1'b0);
        check_bit("bp release in_ready", in_ready, 1'b1);
        words = kc1;
        run_block("bp next", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff);

        // reset during the 5th ROUND cycle
        in_block = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_vec("midrst round_idx before", 128'(round_idx), 128'd5);
        rst_n = 1'b0;
        #1;
        check_bit("midrst busy", busy, 1'b0);
        check_bit("midrst in_ready", in_ready, 1'b0);
        check_vec("midrst round_idx", 128'(round_idx), 128'd0);
        check_vec("midrst rnd_key_o", rnd_key_o, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw = 1'b1;
        end
        check_bit("midrst no out_valid", saw, 1'b0);
        check_bit("midrst in_ready after", in_ready, 1'b1);
        run_block("midrst c1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff);

        // stream of four blocks with both handshakes held high
        pts[0] = 128'h00112233445566778899aabbccddeeff;
        pts[1] = 128'h0123456789abcdeffedcba9876543210;
        pts[2] = 128'hffffffffffffffffffffffffffffffff;
        pts[3] = 128'h5a5a5a5aa5a5a5a5000000013c3c3c3c;
        for (int i = 0; i < 4; i++) begin
            cts[i] = aes_encrypt(pts[i], kc1);
            acc[i] = 0;
        end
        in_idx = 0; out_idx = 0; cyc = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_block  = cts[0];
        while (out_idx < 4 && cyc < 200) begin
            if (in_valid && in_ready) begin
                acc[in_idx] = cyc;
                in_idx++;
            end
            if (out_valid) begin
                check_vec($sformatf("stream out%0d", out_idx), out_block, pts[out_idx]);
                out_idx++;
            end
            @(negedge clk);
            cyc++;
            if (in_idx < 4) in_block = cts[in_idx];
            else            in_valid = 1'b0;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_vec("stream outputs", 128'(out_idx), 128'd4);
        for (int i = 0; i < 3; i++)
            check_vec($sformatf("stream period%0d", i), 128'(acc[i+1] - acc[i]), 128'(PERIOD));
        repeat (2) @(negedge clk);

        // all-zero key
        words = kz;
        run_block("zero block", 128'h0, aes_decrypt(128'h0, kz));
        run_block("zero key known", 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0);
        check_bit("end no X", $isunknown({in_ready, out_valid, out_block, busy, round_idx,
                                          rnd_state_o, rnd_key_o, rnd_last_o}), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
